// File: rtl/i2c_recovery_ctrl_pkg.sv
// Shared encodings and constants for the I2C bus-recovery sequencer.
// The auto-trigger build is selected with I2C_RECOVERY_AUTO_EN.
package i2c_recovery_ctrl_pkg;

   localparam int GUARD_CYCLES = 2;
   localparam int ATT_W        = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_KICK   = 3'd1,
      ST_GUARD  = 3'd2,
      ST_RUN    = 3'd3,
      ST_SETTLE = 3'd4,
      ST_CHECK  = 3'd5
   } state_e;

   // Width needed to hold the values 0..n; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/i2c_recovery_ctrl_stuck_detect.sv
// Stuck-bus detector: counts ce ticks with SDA low and SCL high and pulses
// timeout_o once when the count reaches STUCK_TICKS (built under I2C_RECOVERY_AUTO_EN).
module i2c_stuck_detect
   import i2c_recovery_ctrl_pkg::*;
#(
   parameter int STUCK_TICKS = 25
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ce_i,
   input  logic sda_in_i,
   input  logic scl_in_i,
   input  logic hold_i,
   output logic timeout_o
);

   localparam int            CW      = cnt_width(STUCK_TICKS);
   localparam logic [CW-1:0] CNT_MAX = CW'(STUCK_TICKS);

   logic [CW-1:0] cnt_q;
   logic          timeout_q;
   logic          stuck;

   assign stuck = ~sda_in_i & scl_in_i;

   // Saturates at CNT_MAX so the pulse fires once per stuck episode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         if (hold_i || !stuck) begin
            cnt_q <= '0;
         end else if (ce_i && (cnt_q != CNT_MAX)) begin
            cnt_q     <= cnt_q + 1'b1;
            timeout_q <= (cnt_q == (CNT_MAX - 1'b1));
         end
      end
   end

   assign timeout_o = timeout_q;

endmodule

// File: rtl/i2c_recovery_ctrl.sv
// I2C bus-recovery sequencer: launches the recovery engine, re-checks SDA and
// retries up to MAX_ATTEMPTS. I2C_RECOVERY_AUTO_EN adds the stuck-bus auto trigger.
//
// state  | meaning
// IDLE   | waiting for sw_start or stuck timeout
// KICK   | one-cycle eng_start pulse, attempt counted
// GUARD  | GUARD_CYCLES clocks with eng_busy ignored
// RUN    | engine toggling SCL, wait for eng_busy low
// SETTLE | wait SETTLE_TICKS ce ticks for the bus to settle
// CHECK  | sample SDA: done, retry or fail
module i2c_recovery_ctrl
   import i2c_recovery_ctrl_pkg::*;
#(
   parameter int STUCK_TICKS  = 25,
   parameter int SETTLE_TICKS = 4,
   parameter int MAX_ATTEMPTS = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce_i,
   input  logic             sda_in_i,
   input  logic             scl_in_i,
   input  logic             sw_start_i,
   input  logic             clr_fail_i,
   input  logic             eng_busy_i,
   output logic             eng_start_o,
   output logic             bus_sel_o,
   output logic             busy_o,
   output logic             fail_o,
   output logic [ATT_W-1:0] attempts_o
);

   localparam int               GW          = cnt_width(GUARD_CYCLES);
   localparam int               SW          = cnt_width(SETTLE_TICKS);
   localparam logic [GW-1:0]    GUARD_LAST  = GW'(GUARD_CYCLES - 1);
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_TICKS - 1);
   localparam logic [ATT_W-1:0] ATT_MAX     = ATT_W'(MAX_ATTEMPTS);

   state_e           state_q;
   logic [GW-1:0]    guard_q;
   logic [SW-1:0]    settle_q;
   logic [ATT_W-1:0] attempts_q;
   logic             eng_start_q;
   logic             bus_sel_q;
   logic             busy_q;
   logic             fail_q;
   logic             timeout;
   logic             trigger;

`ifdef I2C_RECOVERY_AUTO_EN
   i2c_stuck_detect #(
      .STUCK_TICKS (STUCK_TICKS)
   ) u_stuck_detect (
      .clk       (clk),
      .rst_n     (rst_n),
      .ce_i      (ce_i),
      .sda_in_i  (sda_in_i),
      .scl_in_i  (scl_in_i),
      .hold_i    (busy_q),
      .timeout_o (timeout)
   );
`else
   logic unused_stuck_cfg;
   assign unused_stuck_cfg = ^{STUCK_TICKS, scl_in_i};
   assign timeout          = 1'b0;
`endif

   assign trigger = sw_start_i | timeout;

   // Outputs are loaded alongside the state they belong to, so each is registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         guard_q     <= '0;
         settle_q    <= '0;
         attempts_q  <= '0;
         eng_start_q <= 1'b0;
         bus_sel_q   <= 1'b0;
         busy_q      <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         eng_start_q <= 1'b0;
         if (clr_fail_i) begin
            fail_q <= 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               if (trigger) begin
                  state_q     <= ST_KICK;
                  attempts_q  <= '0;
                  fail_q      <= 1'b0;
                  eng_start_q <= 1'b1;
                  bus_sel_q   <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            ST_KICK: begin
               attempts_q <= attempts_q + 1'b1;
               guard_q    <= '0;
               state_q    <= ST_GUARD;
            end
            ST_GUARD: begin
               if (guard_q == GUARD_LAST) begin
                  state_q <= ST_RUN;
               end else begin
                  guard_q <= guard_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (!eng_busy_i) begin
                  state_q   <= ST_SETTLE;
                  settle_q  <= '0;
                  bus_sel_q <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (ce_i) begin
                  if (settle_q == SETTLE_LAST) begin
                     state_q <= ST_CHECK;
                  end else begin
                     settle_q <= settle_q + 1'b1;
                  end
               end
            end
            ST_CHECK: begin
               if (sda_in_i) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (attempts_q < ATT_MAX) begin
                  state_q     <= ST_KICK;
                  eng_start_q <= 1'b1;
                  bus_sel_q   <= 1'b1;
               end else begin
                  // Placed after the clr_fail clear so a coincident set wins.
                  fail_q  <= 1'b1;
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               bus_sel_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign eng_start_o = eng_start_q;
   assign bus_sel_o   = bus_sel_q;
   assign busy_o      = busy_q;
   assign fail_o      = fail_q;
   assign attempts_o  = attempts_q;

endmodule

// File: tb/tb_i2c_recovery_ctrl.sv
// Self-checking bench for i2c_recovery_ctrl: engine and ce models, a table of
// recovery scenarios, randomized trials against a sequence-level model, and corner cases.
module tb_i2c_recovery_ctrl;

   localparam int STUCK   = 5;
   localparam int SETTLE  = 2;
   localparam int MAXA    = 3;
   localparam int CE_DIV  = 10;
   localparam int ENG_CYC = 30;
`ifdef I2C_RECOVERY_AUTO_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   typedef struct {
      bit use_sw;
      int k;
      bit clr_hold;
      bit poke;
      int exp_starts;
      int exp_att;
      bit exp_fail;
   } vec_t;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b1;
   logic       ce       = 1'b0;
   logic       sda      = 1'b1;
   logic       scl      = 1'b1;
   logic       sw_start = 1'b0;
   logic       clr_fail = 1'b0;
   logic       eng_busy = 1'b0;
   logic       eng_start;
   logic       bus_sel;
   logic       busy;
   logic       fail;
   logic [3:0] attempts;

   int total = 0;
   int bad   = 0;

   int ce_ph     = 0;
   int eng_cnt   = 0;
   int n_starts  = 0;
   int k_plan    = 0;
   bit plan_mode = 1'b0;
   bit sda_lvl   = 1'b1;
   bit mon_en    = 1'b1;
   bit in_settle = 1'b0;
   int sel_len   = 0;
   int settle_ce = 0;

   always #5 clk = ~clk;

   i2c_recovery_ctrl #(
      .STUCK_TICKS  (STUCK),
      .SETTLE_TICKS (SETTLE),
      .MAX_ATTEMPTS (MAXA)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ce_i        (ce),
      .sda_in_i    (sda),
      .scl_in_i    (scl),
      .sw_start_i  (sw_start),
      .clr_fail_i  (clr_fail),
      .eng_busy_i  (eng_busy),
      .eng_start_o (eng_start),
      .bus_sel_o   (bus_sel),
      .busy_o      (busy),
      .fail_o      (fail),
      .attempts_o  (attempts)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: sample outputs at negedge, drive this cycle's inputs, monitor run timing.
   task automatic step();
      @(negedge clk);
      ce    = (ce_ph == CE_DIV - 1);
      ce_ph = (ce_ph + 1) % CE_DIV;
      if (eng_start === 1'b1) begin
         n_starts++;
         eng_cnt = ENG_CYC;
      end
      eng_busy = (eng_cnt > 0);
      if (eng_cnt > 0) eng_cnt--;
      sda = plan_mode ? (n_starts > k_plan) : sda_lvl;
      if (mon_en) begin
         if (in_settle) begin
            if (bus_sel === 1'b1 || busy !== 1'b1) begin
               check("settle_ticks", settle_ce, SETTLE);
               in_settle = 1'b0;
            end else if (ce) begin
               settle_ce++;
            end
         end
         if (bus_sel === 1'b1) begin
            sel_len++;
         end else if (sel_len > 0) begin
            check("bus_sel_len", sel_len, ENG_CYC + 1);
            sel_len   = 0;
            in_settle = 1'b1;
            settle_ce = ce ? 1 : 0;
         end
      end
   endtask

   // k: number of engine runs after which SDA is still low (-1 = SDA high from the start).
   task automatic do_trial(input bit use_sw, input int k, input bit clr_hold, input bit poke,
                           input int exp_starts, input int exp_att, input bit exp_fail,
                           input string tag);
      int budget;
      int ce_idle;
      bit sw;
      sw        = use_sw || !AUTO;
      n_starts  = 0;
      k_plan    = k;
      plan_mode = 1'b1;
      if (sw) begin
         step();
         sw_start = 1'b1;
         step();
         sw_start = 1'b0;
         check({tag, "_kick"}, {eng_start, bus_sel, busy}, 3'b111);
      end else begin
         ce_idle = 0;
         budget  = 0;
         while (eng_start !== 1'b1 && budget < STUCK * CE_DIV * 3) begin
            step();
            if (ce && eng_start !== 1'b1) ce_idle++;
            budget++;
         end
         check({tag, "_auto_ticks"}, ce_idle, STUCK);
      end
      check({tag, "_fail_cleared"}, fail, 0);
      check({tag, "_att0"}, attempts, 0);
      clr_fail = clr_hold;
      budget   = 0;
      do begin
         step();
         budget++;
         sw_start = poke && (bus_sel === 1'b1) && ($urandom_range(0, 2) == 0);
      end while (busy === 1'b1 && budget < 4000);
      sw_start  = 1'b0;
      clr_fail  = 1'b0;
      plan_mode = 1'b0;
      sda_lvl   = 1'b1;
      check({tag, "_done"}, busy, 0);
      check({tag, "_starts"}, n_starts, exp_starts);
      check({tag, "_attempts"}, attempts, exp_att);
      check({tag, "_fail"}, fail, exp_fail);
   endtask

   vec_t vt[7];

   initial begin
      int cnt;
      int k;
      int m_starts;
      bit m_fail;
      vt[0] = '{1'b1, -1, 1'b0, 1'b0, 1, 1, 1'b0};
      vt[1] = '{1'b0,  0, 1'b0, 1'b0, 1, 1, 1'b0};
      vt[2] = '{1'b1,  5, 1'b0, 1'b0, 3, 3, 1'b1};
      vt[3] = '{1'b1,  1, 1'b0, 1'b1, 2, 2, 1'b0};
      vt[4] = '{1'b1,  2, 1'b0, 1'b0, 3, 3, 1'b0};
      vt[5] = '{1'b1,  3, 1'b1, 1'b0, 3, 3, 1'b1};
      vt[6] = '{1'b0,  7, 1'b0, 1'b1, 3, 3, 1'b1};

      #1 rst_n = 1'b0;
      repeat (3) step();
      check("reset_outs", {eng_start, bus_sel, busy, fail, attempts}, 0);
      rst_n = 1'b1;
      repeat (3) step();

      for (int i = 0; i < 7; i++) begin
         do_trial(vt[i].use_sw, vt[i].k, vt[i].clr_hold, vt[i].poke,
                  vt[i].exp_starts, vt[i].exp_att, vt[i].exp_fail, $sformatf("vec%0d", i));
         repeat (3) step();
      end

      // Sticky fail holds, then clr_fail clears it; attempts keeps its value.
      repeat (5) step();
      check("fail_sticky", fail, 1);
      clr_fail = 1'b1;
      step();
      clr_fail = 1'b0;
      check("fail_clr", fail, 0);
      check("att_hold", attempts, MAXA);

      // A single SCL-low clock breaks a stuck run: 4 + 4 ticks never times out.
      n_starts = 0;
      sda_lvl  = 1'b0;
      cnt = 0;
      while (cnt < STUCK - 1) begin step(); if (ce) cnt++; end
      scl = 1'b0;
      step();
      scl = 1'b1;
      cnt = 0;
      while (cnt < STUCK - 1) begin step(); if (ce) cnt++; end
      repeat (5) step();
      check("det_reset_no_start", n_starts, 0);
      sda_lvl = 1'b1;
      repeat (3) step();

      // sw_start in the same cycle the stuck timeout fires: one sequence only.
      n_starts  = 0;
      k_plan    = 0;
      plan_mode = 1'b1;
      cnt = 0;
      while (cnt < STUCK) begin step(); if (ce) cnt++; end
      step();
      sw_start = 1'b1;
      step();
      sw_start = 1'b0;
      check("coincide_kick", eng_start, 1);
      cnt = 0;
      while (busy === 1'b1 && cnt < 2000) begin step(); cnt++; end
      plan_mode = 1'b0;
      sda_lvl   = 1'b1;
      check("coincide_starts", n_starts, 1);
      check("coincide_fail", fail, 0);
      repeat (3) step();

      // Randomized trials against the sequence-level model.
      for (int t = 0; t < 12; t++) begin
         k        = int'($urandom_range(0, 5)) - 1;
         m_starts = (k < MAXA) ? ((k < 0) ? 1 : k + 1) : MAXA;
         m_fail   = (k >= MAXA);
         do_trial(1'($urandom_range(0, 1)), k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  m_starts, m_starts, m_fail, $sformatf("rnd%0d", t));
         repeat (int'($urandom_range(1, 7))) step();
      end

      // Reset during RUN releases the bus immediately.
      mon_en    = 1'b0;
      plan_mode = 1'b0;
      sda_lvl   = 1'b1;
      n_starts  = 0;
      step();
      sw_start = 1'b1;
      step();
      sw_start = 1'b0;
      repeat (10) step();
      check("rst_pre_sel", bus_sel, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_outs", {eng_start, bus_sel, busy, fail, attempts}, 0);
      eng_cnt = 0;
      repeat (2) step();
      rst_n     = 1'b1;
      sel_len   = 0;
      in_settle = 1'b0;
      mon_en    = 1'b1;
      repeat (3) step();
      do_trial(1'b1, -1, 1'b0, 1'b0, 1, 1, 1'b0, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
